// File: rtl/irq_priority_controller.sv
// Interrupt priority controller: latches per-source requests (edge or level),
// masks them, and presents one winner at a time to a consumer that acks it.
module irq_priority_controller #(
    parameter int SRC_NUM     = 4,
    parameter int ID_WIDTH    = 2,
    parameter int ROUND_ROBIN = 0,
    parameter int EDGE_MODE   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SRC_NUM-1:0]  src_irq,
    input  logic                mask_we,
    input  logic [SRC_NUM-1:0]  mask_in,
    output logic [SRC_NUM-1:0]  mask_out,
    output logic [SRC_NUM-1:0]  pending,
    output logic                irq_out,
    output logic [ID_WIDTH-1:0] irq_id,
    input  logic                irq_ack,
    output logic [1:0]          fsm_state_o
);

    // Handshake: irq_out is the valid and irq_id its payload; irq_ack is a
    // one-cycle ready that only counts while irq_out is high, retiring the grant.

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [SRC_NUM-1:0]  prev_q;
    logic [SRC_NUM-1:0]  pending_q, pending_d;
    logic [SRC_NUM-1:0]  mask_q, mask_d;
    logic                irq_out_q, irq_out_d;
    logic [ID_WIDTH-1:0] irq_id_q, irq_id_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic [SRC_NUM-1:0]  eligible;
    logic [SRC_NUM-1:0]  rise;
    logic [SRC_NUM-1:0]  ack_clr;
    logic [ID_WIDTH-1:0] search_base;
    logic [ID_WIDTH-1:0] winner_lo;
    logic [ID_WIDTH-1:0] winner_hi;
    logic                found_hi;
    logic [ID_WIDTH-1:0] winner;
    logic [ID_WIDTH-1:0] ptr_next;
    logic                retire;

    assign eligible    = pending_q & mask_q;
    assign rise        = src_irq & ~prev_q;
    assign search_base = (ROUND_ROBIN != 0) ? rr_ptr_q : '0;

    // Two passes give a wrapping search without modulo arithmetic: prefer the
    // lowest eligible index at or above the base, else the lowest overall.
    always_comb begin : arbiter
        winner_lo = '0;
        winner_hi = '0;
        found_hi  = 1'b0;
        for (int i = SRC_NUM - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner_lo = ID_WIDTH'(i);
            end
        end
        for (int i = SRC_NUM - 1; i >= 0; i--) begin
            if (eligible[i] && (ID_WIDTH'(i) >= search_base)) begin
                winner_hi = ID_WIDTH'(i);
                found_hi  = 1'b1;
            end
        end
        winner = found_hi ? winner_hi : winner_lo;
    end

    assign ptr_next = (winner == ID_WIDTH'(SRC_NUM - 1)) ? '0 : (winner + ID_WIDTH'(1));

    always_comb begin : ack_decode
        ack_clr = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            ack_clr[i] = (irq_id_q == ID_WIDTH'(i));
        end
    end

    always_comb begin : fsm
        state_d   = state_q;
        irq_out_d = irq_out_q;
        irq_id_d  = irq_id_q;
        rr_ptr_d  = rr_ptr_q;
        retire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d   = ST_ASSERT;
                    irq_out_d = 1'b1;
                    irq_id_d  = winner;
                    if (ROUND_ROBIN != 0) begin
                        rr_ptr_d = ptr_next;
                    end
                end
            end
            ST_ASSERT: begin
                if (irq_ack) begin
                    state_d   = ST_GAP;
                    irq_out_d = 1'b0;
                    retire    = 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                irq_out_d = 1'b0;
            end
        endcase
    end

    // A fresh edge arriving on the retire edge wins over the clear.
    always_comb begin : pending_next
        if (EDGE_MODE != 0) begin
            pending_d = (pending_q & ~({SRC_NUM{retire}} & ack_clr)) | rise;
        end else begin
            pending_d = src_irq;
        end
        mask_d = mask_we ? mask_in : mask_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            irq_out_q <= 1'b0;
            irq_id_q  <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= src_irq;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            irq_out_q <= irq_out_d;
            irq_id_q  <= irq_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign mask_out    = mask_q;
    assign pending     = pending_q;
    assign irq_out     = irq_out_q;
    assign irq_id      = irq_id_q;
    assign fsm_state_o = state_q;

endmodule

// File: doc/irq_priority_controller.md
Name: irq_priority_controller

Overview:
- Parametrised successor to the single-output multicore interrupt combiner.
- Latches per-source interrupt requests (edge or level mode) and applies a software-writable mask.
- Arbitrates by fixed priority or round-robin, presents one request plus a source ID to the consumer, and retires it on a one-cycle acknowledge.
- Sits between the core interrupt lines and the interrupt-servicing core/bus master.

Parameters:
- SRC_NUM, 4, number of interrupt sources (2..32).
- ID_WIDTH, 2, width of irq_id; must satisfy 2**ID_WIDTH >= SRC_NUM.
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- EDGE_MODE, 1, 1 = latch on rising edge until ack; 0 = level-sensitive, no latching.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- src_irq  input  SRC_NUM  raw interrupt lines, one per source.
- mask_we  input  1  when high, mask register loads mask_in.
- mask_in  input  SRC_NUM  new enable mask; 1 = enabled.
- mask_out  output  SRC_NUM  current mask register.
- pending  output  SRC_NUM  pending register, masked and unmasked.
- irq_out  output  1  registered request to consumer.
- irq_id  output  ID_WIDTH  index of granted source; valid while irq_out = 1.
- irq_ack  input  1  consumer acknowledge; only meaningful while irq_out = 1.

Behaviour:
- Reset (reset = 1 at a clock edge):
  - pending = 0, mask_out = all ones, irq_out = 0, irq_id = 0.
  - Round-robin pointer = 0, edge-history register = 0, FSM = IDLE.
  - Reset mid-ASSERT drops irq_out on the same edge; no ack is required.
- Edge detect (EDGE_MODE = 1):
  - prev = src_irq registered each cycle.
  - Edge on source i when src_irq[i] = 1 and prev[i] = 0; pending[i] is set at that edge.
  - A source held high produces exactly one edge.
- Level mode (EDGE_MODE = 0):
  - pending = src_irq registered each cycle.
  - irq_ack does not clear pending; the source must deassert itself.
- Masking:
  - mask_we loads mask_in at the edge.
  - Masked sources still set pending but are not arbitrated.
  - Unmasking a pending source makes it eligible the next cycle.
- Eligible set = pending & mask_out.
- FSM states: IDLE, ASSERT, GAP.
  - IDLE: if eligible != 0 -> ASSERT; irq_id = winner and irq_out = 1 at that edge; otherwise stay in IDLE.
  - ASSERT: irq_out and irq_id are held stable.
  - ASSERT with irq_ack = 1 -> GAP; irq_out = 0; in EDGE_MODE, pending[irq_id] cleared at the same edge.
  - ASSERT with irq_ack = 0 -> stay in ASSERT. Masking the granted source while in ASSERT does not revoke it.
  - GAP -> IDLE unconditionally. This guarantees irq_out is low for at least 1 cycle between grants.
- Latency:
  - src_irq rising before edge n -> pending set at edge n -> irq_out = 1 after edge n+1.
  - Ack sampled at edge m -> next irq_out no earlier than after edge m+2.
- Fixed priority: lowest eligible index wins.
- Round-robin:
  - Search starts at pointer, wrapping SRC_NUM-1 -> 0.
  - On grant, pointer = (winner + 1) mod SRC_NUM. Wrap-around must be correct for non-power-of-two SRC_NUM.
- Simultaneous set and clear on the same source (new edge at the ack edge): set wins; pending stays 1, and the source is re-requested after GAP.
- irq_ack outside ASSERT is ignored.
- Unused high bits of irq_id are 0.

Test Plan:
- Reset, then pulse src_irq = 4'b0001 for 1 cycle -> pending = 0001 one cycle later; irq_out = 1, irq_id = 0 the next cycle; ack -> pending = 0000, irq_out = 0.
- Fixed priority: src_irq = 4'b0110 in one cycle -> irq_id = 1 first. Ack -> 1 GAP cycle with irq_out = 0 -> irq_id = 2. Ack -> IDLE, pending = 0000.
- ROUND_ROBIN = 1: src_irq = 4'b1111 one cycle, ack every grant -> ids 0,1,2,3 in order. Second burst of 4'b1111 -> ids 0,1,2,3 again (pointer wrapped to 0).
- Masking: mask_in = 4'b1011 with mask_we, then pulse source 2 -> pending = 0100, irq_out stays 0 for 10 cycles. Write mask 4'b1111 -> irq_out = 1, irq_id = 2 two cycles later.
- Edge while acking: source 3 granted; re-pulse src_irq[3] on the ack cycle -> pending[3] remains 1 -> irq_out reasserts with irq_id = 3 after GAP. A held-high source yields only one request.
- Reset mid-ASSERT: irq_out = 1, assert reset 1 cycle -> irq_out = 0, pending = 0, mask_out = 1111 next cycle. EDGE_MODE = 0 variant: ack without src_irq dropping -> same id re-granted after GAP.
